// File: rtl/pc_ctrl_unit.sv
// Fetch-stage PC register with next-PC selection, condition evaluation against
// N/V/Z flags, stall/halt handling and a circular return-address stack.
module pc_ctrl_unit #(
  parameter int unsigned PC_W      = 16,
  parameter int unsigned OFF_W     = 9,
  parameter int unsigned RAS_DEPTH = 4,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int unsigned INC       = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              br_valid,
  input  logic              br_reg,
  input  logic [2:0]        br_cond,
  input  logic [OFF_W-1:0]  br_off,
  input  logic [PC_W-1:0]   reg_target,
  input  logic [2:0]        flags,
  input  logic              call,
  input  logic              ret,
  input  logic              hlt,
  output logic [PC_W-1:0]   pc_out,
  output logic [PC_W-1:0]   pc_next,
  output logic              taken,
  output logic              halted,
  output logic              ras_empty,
  output logic              ras_full,
  output logic              ras_ovf,
  output logic              ras_unf
);

  localparam int unsigned PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(RAS_DEPTH - 1);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(RAS_DEPTH);

  logic [PC_W-1:0]  ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0] sp;
  logic [CNT_W-1:0] count;

  logic                    cond_true;
  logic                    halt_any;
  logic                    do_push;
  logic                    do_pop;
  logic [PTR_W-1:0]        top_ptr;
  logic [PC_W-1:0]         seq_pc;
  logic [PC_W-1:0]         off_ext;
  logic signed [OFF_W-1:0] off_s;

  assign ras_empty = (count == '0);
  assign ras_full  = (count == DEPTH_C);
  assign off_s     = br_off;

  // Condition decode, next-PC priority and stack control
  always_comb begin
    cond_true = 1'b0;
    case (br_cond)
      3'b000:  cond_true = !flags[0];
      3'b001:  cond_true = flags[0];
      3'b010:  cond_true = !flags[0] && !flags[2];
      3'b011:  cond_true = flags[2];
      3'b100:  cond_true = flags[0] || (!flags[0] && !flags[2]);
      3'b101:  cond_true = flags[2] || flags[0];
      3'b110:  cond_true = flags[1];
      default: cond_true = 1'b1;
    endcase

    taken    = (br_valid || br_reg) && cond_true;
    halt_any = halted || hlt;
    seq_pc   = pc_out + PC_W'(INC);
    off_ext  = PC_W'(off_s);
    top_ptr  = (sp == '0) ? LAST_PTR : sp - PTR_W'(1);

    pc_next = seq_pc;
    if (halt_any)                   pc_next = pc_out;
    else if (ret && !ras_empty)     pc_next = ras_mem[top_ptr];
    else if (br_reg && cond_true)   pc_next = reg_target;
    else if (br_valid && cond_true) pc_next = seq_pc + (off_ext << 1);

    // A halt request in the same cycle also suppresses stack traffic
    do_pop  = ret && !halt_any && !stall;
    do_push = call && taken && !ret && !halt_any && !stall;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_out  <= RESET_PC;
      halted  <= 1'b0;
      ras_ovf <= 1'b0;
      ras_unf <= 1'b0;
      sp      <= '0;
      count   <= '0;
      for (int i = 0; i < RAS_DEPTH; i++) ras_mem[i] <= '0;
    end else begin
      if (hlt) halted <= 1'b1;
      if (!stall) pc_out <= pc_next;
      if (do_pop) begin
        if (ras_empty) begin
          ras_unf <= 1'b1;
        end else begin
          sp    <= top_ptr;
          count <= count - CNT_W'(1);
        end
      end else if (do_push) begin
        // Full stack wraps: oldest entry is overwritten in place
        ras_mem[sp] <= seq_pc;
        sp          <= (sp == LAST_PTR) ? '0 : sp + PTR_W'(1);
        if (ras_full) ras_ovf <= 1'b1;
        else          count   <= count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pc_ctrl_unit.sv
// Bench for pc_ctrl_unit: directed vector table, hand-written corner sequences
// and random stimulus checked against a queue-based reference model.
module tb_pc_ctrl_unit;

  logic        clk, rst_n, stall, br_valid, br_reg, call, ret, hlt;
  logic [2:0]  br_cond, flags;
  logic [8:0]  br_off;
  logic [15:0] reg_target, pc_out, pc_next;
  logic        taken, halted, ras_empty, ras_full, ras_ovf, ras_unf;

  pc_ctrl_unit dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .br_valid(br_valid), .br_reg(br_reg),
    .br_cond(br_cond), .br_off(br_off), .reg_target(reg_target), .flags(flags),
    .call(call), .ret(ret), .hlt(hlt), .pc_out(pc_out), .pc_next(pc_next),
    .taken(taken), .halted(halted), .ras_empty(ras_empty), .ras_full(ras_full),
    .ras_ovf(ras_ovf), .ras_unf(ras_unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       bv;
    logic       br;
    logic [2:0] cond;
    logic [8:0] off;
    logic [15:0] tgt;
    logic [2:0] fl;
    logic       cl;
    logic       rt;
    logic       st;
    logic       h;
  } in_t;

  typedef struct {
    in_t         i;
    logic        exp_taken;
    logic [15:0] exp_next;
    logic [15:0] exp_pc;
  } rec_t;

  int errors = 0;
  int checks = 0;

  // Reference model state
  int unsigned m_pc;
  logic [15:0] m_stk[$];
  bit          m_halt, m_ovf, m_unf;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic in_t mk(input logic bv, input logic br, input logic [2:0] cond,
                             input logic [8:0] off, input logic [15:0] tgt,
                             input logic [2:0] fl, input logic cl, input logic rt,
                             input logic st, input logic h);
    in_t r;
    r.bv = bv; r.br = br; r.cond = cond; r.off = off; r.tgt = tgt;
    r.fl = fl; r.cl = cl; r.rt = rt; r.st = st; r.h = h;
    return r;
  endfunction

  function automatic in_t idle();
    return mk(1'b0, 1'b0, 3'd0, 9'd0, 16'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endfunction

  function automatic in_t ld(input logic [15:0] a);
    return mk(1'b0, 1'b1, 3'd7, 9'd0, a, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endfunction

  function automatic bit cond_ok(input logic [2:0] c, input logic [2:0] f);
    bit n, v, z;
    n = f[2]; v = f[1]; z = f[0];
    case (c)
      3'd0: return !z;
      3'd1: return z;
      3'd2: return !z && !n;
      3'd3: return n;
      3'd4: return z || (!z && !n);
      3'd5: return n || z;
      3'd6: return v;
      default: return 1'b1;
    endcase
  endfunction

  task automatic drive(input in_t v);
    br_valid = v.bv; br_reg = v.br; br_cond = v.cond; br_off = v.off;
    reg_target = v.tgt; flags = v.fl; call = v.cl; ret = v.rt; stall = v.st; hlt = v.h;
  endtask

  task automatic model_reset();
    m_pc = 0; m_stk.delete(); m_halt = 0; m_ovf = 0; m_unf = 0;
  endtask

  // One clock: model predicts combinational outputs and post-edge state
  task automatic step(input in_t v);
    bit c, tk, hany;
    int so;
    logic [15:0] nxt, inc;
    drive(v);
    c    = cond_ok(v.cond, v.fl);
    tk   = (v.bv || v.br) && c;
    hany = m_halt || v.h;
    so   = int'(v.off);
    if (v.off[8]) so = so - 512;
    inc  = 16'(m_pc + 2);
    if (hany)                           nxt = 16'(m_pc);
    else if (v.rt && m_stk.size() > 0)  nxt = m_stk[$];
    else if (v.br && c)                 nxt = v.tgt;
    else if (v.bv && c)                 nxt = 16'(int'(m_pc) + 2 + 2 * so);
    else                                nxt = inc;
    #1;
    chk("taken", 32'(taken), 32'(tk));
    chk("pc_next", 32'(pc_next), 32'(nxt));
    if (!v.st) begin
      if (!hany) begin
        if (v.rt) begin
          if (m_stk.size() == 0) m_unf = 1;
          else void'(m_stk.pop_back());
        end else if (v.cl && tk) begin
          m_stk.push_back(inc);
          if (m_stk.size() > 4) begin
            void'(m_stk.pop_front());
            m_ovf = 1;
          end
        end
      end
      m_pc = 32'(nxt);
    end
    if (v.h) m_halt = 1;
    @(posedge clk);
    #1;
    chk("pc_out", 32'(pc_out), m_pc);
    chk("halted", 32'(halted), 32'(m_halt));
    chk("ras_empty", 32'(ras_empty), 32'(m_stk.size() == 0));
    chk("ras_full", 32'(ras_full), 32'(m_stk.size() == 4));
    chk("ras_ovf", 32'(ras_ovf), 32'(m_ovf));
    chk("ras_unf", 32'(ras_unf), 32'(m_unf));
  endtask

  task automatic do_reset();
    drive(idle());
    rst_n = 1'b0;
    #2;
    model_reset();
    chk("rst pc_out", 32'(pc_out), 32'h0);
    chk("rst halted", 32'(halted), 32'h0);
    chk("rst empty", 32'(ras_empty), 32'h1);
    chk("rst full", 32'(ras_full), 32'h0);
    chk("rst ovf", 32'(ras_ovf), 32'h0);
    chk("rst unf", 32'(ras_unf), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  rec_t tv[14];

  initial begin
    rst_n = 1'b0;
    drive(idle());
    model_reset();

    // Directed table, rows run back to back from reset
    tv[0]  = '{ld(16'h0010), 1'b1, 16'h0010, 16'h0010};
    tv[1]  = '{mk(1,0,3'd7,9'h012,16'h0,3'b000,0,0,0,0), 1'b1, 16'h0036, 16'h0036};
    tv[2]  = '{ld(16'h0100), 1'b1, 16'h0100, 16'h0100};
    tv[3]  = '{mk(1,0,3'd1,9'h1FF,16'h0,3'b001,0,0,0,0), 1'b1, 16'h0100, 16'h0100};
    tv[4]  = '{mk(1,0,3'd0,9'h004,16'h0,3'b001,0,0,0,0), 1'b0, 16'h0102, 16'h0102};
    tv[5]  = '{mk(1,0,3'd3,9'h000,16'h0,3'b100,0,0,0,0), 1'b1, 16'h0104, 16'h0104};
    tv[6]  = '{mk(1,0,3'd2,9'h004,16'h0,3'b000,0,0,0,0), 1'b1, 16'h010E, 16'h010E};
    tv[7]  = '{mk(1,0,3'd2,9'h004,16'h0,3'b001,0,0,0,0), 1'b0, 16'h0110, 16'h0110};
    tv[8]  = '{mk(0,1,3'd4,9'h000,16'h0200,3'b001,0,0,0,0), 1'b1, 16'h0200, 16'h0200};
    tv[9]  = '{mk(0,1,3'd5,9'h000,16'h0300,3'b000,0,0,0,0), 1'b0, 16'h0202, 16'h0202};
    tv[10] = '{mk(1,0,3'd6,9'h100,16'h0,3'b010,0,0,0,0), 1'b1, 16'h0004, 16'h0004};
    tv[11] = '{mk(1,0,3'd6,9'h100,16'h0,3'b000,0,0,0,0), 1'b0, 16'h0006, 16'h0006};
    tv[12] = '{mk(1,0,3'd7,9'h010,16'h0,3'b000,0,0,1,0), 1'b1, 16'h0028, 16'h0006};
    tv[13] = '{mk(0,0,3'd7,9'h010,16'h0,3'b000,0,0,0,0), 1'b0, 16'h0008, 16'h0008};

    // Reset, run, reset mid-run, then sequential counting
    do_reset();
    step(ld(16'h0abc));
    step(idle());
    do_reset();
    for (int k = 1; k <= 3; k++) begin
      step(idle());
      chk("seq after reset", 32'(pc_out), 32'(2 * k));
    end

    do_reset();
    for (int k = 0; k < 14; k++) begin
      drive(tv[k].i);
      #1;
      chk($sformatf("tv%0d taken", k), 32'(taken), 32'(tv[k].exp_taken));
      chk($sformatf("tv%0d next", k), 32'(pc_next), 32'(tv[k].exp_next));
      step(tv[k].i);
      chk($sformatf("tv%0d pc", k), 32'(pc_out), 32'(tv[k].exp_pc));
    end

    // Call and return through a register branch
    do_reset();
    step(ld(16'h0040));
    step(mk(0,1,3'd7,9'h0,16'h1000,3'b000,1,0,0,0));
    chk("call pc", 32'(pc_out), 32'h1000);
    chk("call nonempty", 32'(ras_empty), 32'h0);
    step(mk(0,0,3'd0,9'h0,16'h0,3'b000,0,1,0,0));
    chk("ret pc", 32'(pc_out), 32'h0042);

    // Stack overflow wrap then underflow
    do_reset();
    step(ld(16'h0010));
    for (int k = 1; k <= 5; k++)
      step(mk(0,1,3'd7,9'h0,16'((k + 1) * 16),3'b000,1,0,0,0));
    chk("ovf flag", 32'(ras_ovf), 32'h1);
    chk("full flag", 32'(ras_full), 32'h1);
    for (int k = 0; k < 4; k++) begin
      step(mk(0,0,3'd0,9'h0,16'h0,3'b000,0,1,0,0));
      chk("ras pop", 32'(pc_out), 32'(16'h0052 - 16'(k * 16)));
    end
    chk("empty after pops", 32'(ras_empty), 32'h1);
    step(mk(0,0,3'd0,9'h0,16'h0,3'b000,0,1,0,0));
    chk("unf pc", 32'(pc_out), 32'h0024);
    chk("unf flag", 32'(ras_unf), 32'h1);

    // Wrap, stall, halt freeze, reset out of halt
    do_reset();
    step(ld(16'hFFFE));
    step(idle());
    chk("wrap", 32'(pc_out), 32'h0000);
    step(mk(1,0,3'd7,9'h010,16'h0,3'b000,0,0,1,0));
    chk("stall hold", 32'(pc_out), 32'h0000);
    step(mk(0,0,3'd0,9'h0,16'h0,3'b000,0,0,0,1));
    chk("halt set", 32'(halted), 32'h1);
    for (int k = 0; k < 3; k++) step(mk(0,1,3'd7,9'h0,16'h1234,3'b000,1,0,0,0));
    step(mk(0,0,3'd0,9'h0,16'h0,3'b000,0,1,0,0));
    chk("halt frozen", 32'(pc_out), 32'h0000);
    chk("halt no push", 32'(ras_empty), 32'h1);
    do_reset();
    chk("halt cleared", 32'(halted), 32'h0);
    step(mk(0,0,3'd0,9'h0,16'h0,3'b000,0,0,1,1));
    chk("halt under stall", 32'(halted), 32'h1);

    // Random stimulus against the model
    do_reset();
    for (int k = 0; k < 1500; k++) begin
      in_t r;
      r.bv   = 1'($urandom_range(0, 1));
      r.br   = ($urandom_range(0, 3) == 0);
      r.cond = 3'($urandom);
      r.off  = 9'($urandom);
      r.tgt  = 16'($urandom) & 16'hFFFE;
      r.fl   = 3'($urandom);
      r.cl   = ($urandom_range(0, 2) == 0);
      r.rt   = ($urandom_range(0, 3) == 0);
      r.st   = ($urandom_range(0, 7) == 0);
      r.h    = 1'b0;
      step(r);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
